// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encoding and counter widths.
package cpu_ctrl_pkg;

  localparam int WAIT_W = 16;
  localparam int PERF_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FAULT    = 2'd3
  } state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipe-register control outputs shared between the sequencer and datapath.
interface pipeline_ctrl_if;

  logic        start_i;
  logic        idex_memread_i;
  logic [4:0]  idex_rt_i;
  logic [4:0]  ifid_rs_i;
  logic [4:0]  ifid_rt_i;
  logic        branch_taken_i;
  logic        dmem_req_i;
  logic        dmem_ack_i;
  logic        pc_write_o;
  logic        ifid_stall_o;
  logic        ifid_flush_o;
  logic        idex_bubble_o;
  logic        pipe_hold_o;
  logic        running_o;
  logic        fault_o;
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_count_o;

  // master: the sequencer; slave: the datapath it steers
  modport master (
    input  start_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
           branch_taken_i, dmem_req_i, dmem_ack_i,
    output pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
           running_o, fault_o, stall_cycles_o, flush_count_o
  );

  modport slave (
    output start_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
           branch_taken_i, dmem_req_i, dmem_ack_i,
    input  pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
           running_o, fault_o, stall_cycles_o, flush_count_o
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard compare: EX load destination against both ID sources, r0 never hazards.
module load_use_detect (
  input  logic       memread,
  input  logic [4:0] rt_ex,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  output logic       hazard
);

  assign hazard = memread && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (rt_ex == rt_id));

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: start-up, load-use stall, branch flush, dmem freeze + watchdog.
// Optional perf counters enabled by defining PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pipeline_ctrl_if.master bus
);

  localparam logic [1:0] IDLE     = ST_IDLE;
  localparam logic [1:0] RUN      = ST_RUN;
  localparam logic [1:0] MEM_WAIT = ST_MEM_WAIT;
  localparam logic [1:0] FAULT    = ST_FAULT;

  logic [1:0]        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              load_use, freeze;
  logic              rd_pc, rd_stall, rd_flush, rd_bubble, rd_hold;
  logic              pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_hold, fault;
  logic              running;

  load_use_detect u_load_use_detect (
    .memread (bus.idex_memread_i),
    .rt_ex   (bus.idex_rt_i),
    .rs_id   (bus.ifid_rs_i),
    .rt_id   (bus.ifid_rt_i),
    .hazard  (load_use)
  );

  assign freeze = bus.dmem_req_i && !bus.dmem_ack_i;

  // RUN decode, priority freeze > flush > load-use; reused in the MEM_WAIT ack cycle
  always_comb begin
    rd_pc     = 1'b1;
    rd_stall  = 1'b0;
    rd_flush  = 1'b0;
    rd_bubble = 1'b0;
    rd_hold   = 1'b0;
    if (freeze) begin
      rd_pc    = 1'b0;
      rd_stall = 1'b1;
      rd_hold  = 1'b1;
    end else if (bus.branch_taken_i) begin
      rd_flush  = 1'b1;
      rd_bubble = 1'b1;
    end else if (load_use) begin
      rd_pc     = 1'b0;
      rd_stall  = 1'b1;
      rd_bubble = 1'b1;
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    ifid_stall   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    pipe_hold    = 1'b1;
    fault        = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (bus.start_i) state_nxt = RUN;
      end
      RUN: begin
        pc_write    = rd_pc;
        ifid_stall  = rd_stall;
        ifid_flush  = rd_flush;
        idex_bubble = rd_bubble;
        pipe_hold   = rd_hold;
        if (freeze) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ack_i) begin
          pc_write     = rd_pc;
          ifid_stall   = rd_stall;
          ifid_flush   = rd_flush;
          idex_bubble  = rd_bubble;
          pipe_hold    = rd_hold;
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
          state_nxt = FAULT;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  assign running = (state == RUN) || (state == MEM_WAIT);

  assign bus.pc_write_o    = pc_write;
  assign bus.ifid_stall_o  = ifid_stall;
  assign bus.ifid_flush_o  = ifid_flush;
  assign bus.idex_bubble_o = idex_bubble;
  assign bus.pipe_hold_o   = pipe_hold;
  assign bus.running_o     = running;
  assign bus.fault_o       = fault;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt, flush_cnt;

  // both counters stick at all-ones rather than wrapping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (running && !pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + PERF_W'(1);
      if (ifid_flush && (flush_cnt != '1))           flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end

  assign bus.stall_cycles_o = stall_cnt;
  assign bus.flush_count_o  = flush_cnt;
`else
  assign bus.stall_cycles_o = '0;
  assign bus.flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with MEM_TIMEOUT=4; expected values hand-computed per vector.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  // {pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_hold, running, fault}
  localparam logic [6:0] O_IDLE  = 7'b0100100;
  localparam logic [6:0] O_RUN   = 7'b1000010;
  localparam logic [6:0] O_LU    = 7'b0101010;
  localparam logic [6:0] O_FLUSH = 7'b1011010;
  localparam logic [6:0] O_FRZ   = 7'b0100110;
  localparam logic [6:0] O_FAULT = 7'b0100101;

`ifdef PIPELINE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  pipeline_ctrl_if bus();

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {bus.pc_write_o, bus.ifid_stall_o, bus.ifid_flush_o, bus.idex_bubble_o,
            bus.pipe_hold_o, bus.running_o, bus.fault_o};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clr_in();
    bus.start_i        = 1'b0;
    bus.idex_memread_i = 1'b0;
    bus.idex_rt_i      = 5'd0;
    bus.ifid_rs_i      = 5'd0;
    bus.ifid_rt_i      = 5'd0;
    bus.branch_taken_i = 1'b0;
    bus.dmem_req_i     = 1'b0;
    bus.dmem_ack_i     = 1'b0;
  endtask

  task automatic set_lu(input logic mr, input logic [4:0] rt_ex, input logic [4:0] rs, input logic [4:0] rt);
    bus.idex_memread_i = mr;
    bus.idex_rt_i      = rt_ex;
    bus.ifid_rs_i      = rs;
    bus.ifid_rt_i      = rt;
  endtask

  // reset pulse spanning one edge, then start for one cycle; leaves the FSM in RUN
  task automatic reset_and_start();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.start_i = 1'b1;
    cyc();
    bus.start_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    #3;
    check_val("rst_outs",  32'(outs()), 32'(O_IDLE));
    check_val("rst_stall", bus.stall_cycles_o, 32'd0);
    check_val("rst_flush", bus.flush_count_o, 32'd0);

    cyc();
    rst = 1'b0;
    cyc();
    check_val("idle_no_start", 32'(outs()), 32'(O_IDLE));
    bus.start_i = 1'b1;
    settle();
    check_val("idle_start_cycle", 32'(outs()), 32'(O_IDLE));
    cyc();
    bus.start_i = 1'b0;
    settle();
    check_val("run_first", 32'(outs()), 32'(O_RUN));

    // load-use vectors, one per cycle
    cyc(); set_lu(1'b1, 5'd5, 5'd5, 5'd7); settle();
    check_val("lu_rs", 32'(outs()), 32'(O_LU));
    cyc(); set_lu(1'b1, 5'd5, 5'd3, 5'd5); settle();
    check_val("lu_rt", 32'(outs()), 32'(O_LU));
    cyc(); set_lu(1'b1, 5'd0, 5'd0, 5'd0); settle();
    check_val("lu_r0", 32'(outs()), 32'(O_RUN));
    cyc(); set_lu(1'b0, 5'd5, 5'd5, 5'd5); settle();
    check_val("lu_no_load", 32'(outs()), 32'(O_RUN));
    cyc(); set_lu(1'b1, 5'd9, 5'd4, 5'd6); settle();
    check_val("lu_no_match", 32'(outs()), 32'(O_RUN));
    cyc(); set_lu(1'b1, 5'd5, 5'd5, 5'd0); bus.branch_taken_i = 1'b1; settle();
    check_val("flush_over_lu", 32'(outs()), 32'(O_FLUSH));
    cyc(); clr_in(); settle();
    check_val("run_after_flush", 32'(outs()), 32'(O_RUN));
    check_val("perf_stall_a", bus.stall_cycles_o, PERF ? 32'd2 : 32'd0);
    check_val("perf_flush_a", bus.flush_count_o,  PERF ? 32'd1 : 32'd0);

    // memory freeze: ack on the 4th cycle with a branch pending throughout
    cyc();
    reset_and_start();
    settle();
    check_val("rst2_run", 32'(outs()), 32'(O_RUN));
    check_val("rst2_stall", bus.stall_cycles_o, 32'd0);
    bus.dmem_req_i = 1'b1;
    bus.branch_taken_i = 1'b1;
    settle();
    check_val("frz_run", 32'(outs()), 32'(O_FRZ));
    cyc(); settle();
    check_val("frz_w1", 32'(outs()), 32'(O_FRZ));
    cyc(); settle();
    check_val("frz_w2", 32'(outs()), 32'(O_FRZ));
    cyc(); bus.dmem_ack_i = 1'b1; settle();
    check_val("ack_flush", 32'(outs()), 32'(O_FLUSH));
    cyc(); clr_in(); settle();
    check_val("run_after_ack", 32'(outs()), 32'(O_RUN));
    check_val("perf_stall_b", bus.stall_cycles_o, PERF ? 32'd3 : 32'd0);
    check_val("perf_flush_b", bus.flush_count_o,  PERF ? 32'd1 : 32'd0);
    bus.dmem_req_i = 1'b1;
    bus.dmem_ack_i = 1'b1;
    settle();
    check_val("ack_first_no_frz", 32'(outs()), 32'(O_RUN));
    cyc(); clr_in(); settle();
    check_val("ack_first_run", 32'(outs()), 32'(O_RUN));

    // watchdog: one RUN freeze cycle, then 4 unacked MEM_WAIT cycles, then FAULT
    bus.dmem_req_i = 1'b1;
    settle();
    check_val("to_run_frz", 32'(outs()), 32'(O_FRZ));
    for (int i = 1; i <= 4; i++) begin
      cyc(); settle();
      check_val($sformatf("to_wait%0d", i), 32'(outs()), 32'(O_FRZ));
    end
    cyc(); settle();
    check_val("to_fault", 32'(outs()), 32'(O_FAULT));
    bus.start_i = 1'b1;
    bus.dmem_ack_i = 1'b1;
    cyc(); settle();
    check_val("fault_sticky", 32'(outs()), 32'(O_FAULT));
    clr_in();
    rst = 1'b1;
    settle();
    check_val("fault_rst", 32'(outs()), 32'(O_IDLE));

    // reset asserted mid-MEM_WAIT, no clock edge needed
    cyc();
    reset_and_start();
    bus.dmem_req_i = 1'b1;
    cyc(); cyc(); settle();
    check_val("mw_before_rst", 32'(outs()), 32'(O_FRZ));
    rst = 1'b1;
    #1;
    check_val("mw_rst_outs",  32'(outs()), 32'(O_IDLE));
    check_val("mw_rst_stall", bus.stall_cycles_o, 32'd0);
    check_val("mw_rst_flush", bus.flush_count_o, 32'd0);

    // after reset the wait counter restarts: full 4-cycle window again before FAULT
    cyc();
    clr_in();
    reset_and_start();
    bus.dmem_req_i = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    settle();
    check_val("mw_cnt_cleared", 32'(outs()), 32'(O_FAULT));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
